matrix_key_scanner: RTL and testbench
=====================================

// Module: matrix_key_scanner
// PURPOSE
//  Parametrised ROWS x COLS matrix-keypad scanner with tick-based press/release debounce
//  and active-low column scanning. Emits a one-cycle key_valid pulse with a linear key code.
//  Sits between the keypad pins and the calculator input decoder; replaces the fixed 4x4 scanner.
// PARAMETERS
//  ROWS          4       number of row inputs (sensed, active-low, external pull-ups)
//  COLS          4       number of column outputs (driven, active-low)
//  TICK_DIV      50000   clk cycles per debounce tick (1 ms at 50 MHz); >= 2
//  DEBOUNCE_TK   10      consecutive stable ticks required for press and for release; 1..255
//  SETTLE_CYC    8       clk cycles each scan column is driven before row is sampled; >= 3
//  REPEAT_DLY    500     ticks held before first auto-repeat (KEY_REPEAT_EN only)
//  REPEAT_RATE   100     ticks between auto-repeats (KEY_REPEAT_EN only)
// PORTS
//  clk        in   1                  system clock
//  rst_n      in   1                  asynchronous active-low reset
//  row        in   ROWS               raw row lines, 0 = pulled low by pressed key
//  col        out  COLS               column drive, 0 = driven column
//  key_valid  out  1                  one-cycle pulse: key_code is new/valid
//  key_code   out  $clog2(ROWS*COLS)  r*COLS + c of detected key, held until next key_valid
//  key_held   out  1                  high from key_valid until release debounce completes
//  key_repeat out  1                  high with key_valid when pulse is an auto-repeat
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, col=all 0, key_valid=0, key_code=0, key_held=0,
//   key_repeat=0, counters 0, synchroniser flops all 1. Reset mid-press aborts; no pulse.
//  row passes a 2-FF synchroniser (rs); all decisions use rs. any_low = (rs != all 1).
//  Tick: free-running divider, tick=1 one cycle every TICK_DIV clk; restarts from 0 on reset.
//  FSM (one-hot or binary, registered outputs):
//   IDLE     col=0. any_low -> DB_PRESS, dcnt=0.
//   DB_PRESS on tick: any_low ? dcnt++ : -> IDLE. dcnt==DEBOUNCE_TK -> SCAN, c=0.
//   SCAN     col = ~(1<<c). After SETTLE_CYC clk, sample rs: if any_low -> latch
//            r = lowest index of low row, code=r*COLS+c; -> HIT. Else c++; c==COLS-1 with
//            no hit -> IDLE (bounce, no pulse). Columns scanned 0..COLS-1, first hit wins.
//   HIT      one cycle: key_valid=1, key_code updated, key_held=1, col=0 -> HELD.
//   HELD     col=0. on tick: any_low ? dcnt=0 : dcnt++. dcnt==DEBOUNCE_TK -> IDLE,
//            key_held=0. A release glitch shorter than DEBOUNCE_TK ticks is ignored.
//  Latency press stable->key_valid: 2 clk sync + DEBOUNCE_TK ticks + (c+1)*SETTLE_CYC + 1 clk.
//  Multiple keys: lowest column, then lowest row, wins; extra keys while HELD are ignored
//   (no new pulse until full release). Ghosting not resolved.
//  Counter widths sized by $clog2 of parameter+1; no wrap: counters saturate at terminal count.
//  Release and new press in the same tick: release debounce restarts; no second pulse.
// CONFIGURATION
//  KEY_REPEAT_EN defined: in HELD with key still pressed, rcnt counts ticks; at REPEAT_DLY
//   then every REPEAT_RATE ticks emit key_valid=1, key_repeat=1 for one cycle, same key_code.
//   rcnt clears on entry to HELD and on any release tick.
//  KEY_REPEAT_EN undefined: exactly one key_valid per press; key_repeat tied 0; REPEAT_* unused.
// STRUCTURE
//  Package key_scan_pkg: FSM state encoding (IDLE, DB_PRESS, SCAN, HIT, HELD), CODE_W helper.
//  Sub-module key_tick_gen (TICK_DIV): clk, rst_n -> tick pulse. Scanner FSM, sync and
//   encoder stay in matrix_key_scanner.
// TESTING (sim params: TICK_DIV=4, DEBOUNCE_TK=3, SETTLE_CYC=3, REPEAT_DLY=5, REPEAT_RATE=2)
//  Press r2,c1 held 20 ticks -> one key_valid, key_code=9, key_held=1 until 3 ticks after release.
//  Bounce: row low 2 ticks then high -> no key_valid, FSM back to IDLE, col=0.
//  Press r0,c0 and r3,c3 together -> key_code=0; add r1,c2 while HELD -> no new pulse.
//  Release glitch 1 tick in HELD -> key_held stays 1, no second pulse on return.
//  rst_n low during SCAN -> all outputs reset value immediately; no pulse after rst_n high.
//  KEY_REPEAT_EN, hold r3,c3 -> first pulse code=15, repeats at +5 ticks then every 2 ticks.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared types and width helpers for the matrix keypad scanner.
package key_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DB_PRESS,
      ST_SCAN,
      ST_HIT,
      ST_HELD
   } scan_state_e;

   // Bits needed to index n items; never below 1 so degenerate sizes still elaborate.
   function automatic int code_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_tick_gen.sv
// Debounce tick generator: one-cycle tick every TICK_DIV clk cycles, phase restarts on reset.
module key_tick_gen
   import key_scan_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            TW      = code_w(TICK_DIV);
   localparam logic [TW-1:0] TC_LOAD = TW'(TICK_DIV - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q - TW'(1);
      if (cnt_q == '0) cnt_d = TC_LOAD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= TC_LOAD;
      else        cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/matrix_key_scanner.sv
// ROWS x COLS keypad scanner with tick-based press/release debounce and active-low column scan.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
//
// state    | meaning
// IDLE     | all columns driven, waiting for any row to go low
// DB_PRESS | rows low, counting stable ticks before scanning
// SCAN     | driving one column at a time, sampling rows after settling
// HIT      | one-cycle key_valid with the new key_code
// HELD     | key down, counting stable release ticks (and repeat ticks)
module matrix_key_scanner
   import key_scan_pkg::*;
#(
   parameter int ROWS        = 4,
   parameter int COLS        = 4,
   parameter int TICK_DIV    = 50000,
   parameter int DEBOUNCE_TK = 10,
   parameter int SETTLE_CYC  = 8,
   parameter int REPEAT_DLY  = 500,
   parameter int REPEAT_RATE = 100
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ROWS-1:0]                 row,
   output logic [COLS-1:0]                 col,
   output logic                            key_valid,
   output logic [code_w(ROWS*COLS)-1:0]    key_code,
   output logic                            key_held,
   output logic                            key_repeat
);

   localparam int CODE_W = code_w(ROWS * COLS);
   localparam int RW     = code_w(ROWS);
   localparam int CW     = code_w(COLS);
   localparam int DW     = code_w(DEBOUNCE_TK + 1);
   localparam int SW     = code_w(SETTLE_CYC);

   localparam logic [DW-1:0]   DB_LAST     = DW'(DEBOUNCE_TK - 1);
   localparam logic [DW-1:0]   DB_TC       = DW'(DEBOUNCE_TK);
   localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]   C_LAST      = CW'(COLS - 1);
   localparam logic [COLS-1:0] COL_ONE     = COLS'(1);

   if (TICK_DIV < 2 || DEBOUNCE_TK < 1 || DEBOUNCE_TK > 255 || SETTLE_CYC < 3 ||
       REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("matrix_key_scanner: parameter out of range");
   end

   scan_state_e         state_q, state_d;
   logic [ROWS-1:0]     rs1_q, rs_q;
   logic [DW-1:0]       dcnt_q, dcnt_d;
   logic [SW-1:0]       scnt_q, scnt_d;
   logic [CW-1:0]       c_q, c_d;
   logic [COLS-1:0]     col_q, col_d;
   logic                key_valid_q, key_valid_d;
   logic [CODE_W-1:0]   key_code_q, key_code_d;
   logic                key_held_q, key_held_d;
   logic                tick;
   logic                any_low;
   logic [RW-1:0]       hit_row;
   logic [CODE_W-1:0]   hit_code;

`ifdef KEY_REPEAT_EN
   localparam int            REP_W         = code_w(((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE) + 1);
   localparam logic [REP_W-1:0] REP_DLY_LOAD  = REP_W'(REPEAT_DLY - 1);
   localparam logic [REP_W-1:0] REP_RATE_LOAD = REP_W'(REPEAT_RATE - 1);
   logic [REP_W-1:0]    rcnt_q, rcnt_d;
   logic                key_repeat_q, key_repeat_d;
`endif

   key_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_q <= '1;
         rs_q  <= '1;
      end else begin
         rs1_q <= row;
         rs_q  <= rs1_q;
      end
   end

   assign any_low = (rs_q != '1);

   // Lowest-index low row wins when several keys share the scanned column.
   always_comb begin
      hit_row = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!rs_q[i]) hit_row = RW'(i);
      end
   end

   assign hit_code = CODE_W'(hit_row) * CODE_W'(COLS) + CODE_W'(c_q);

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      scnt_d      = scnt_q;
      c_d         = c_q;
      col_d       = col_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      key_held_d  = key_held_q;
`ifdef KEY_REPEAT_EN
      rcnt_d       = rcnt_q;
      key_repeat_d = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            col_d = '0;
            if (any_low) begin
               state_d = ST_DB_PRESS;
               dcnt_d  = '0;
            end
         end
         ST_DB_PRESS: begin
            if (tick) begin
               if (!any_low) begin
                  state_d = ST_IDLE;
               end else if (dcnt_q == DB_LAST) begin
                  state_d = ST_SCAN;
                  dcnt_d  = DB_TC;
                  c_d     = '0;
                  scnt_d  = SETTLE_LOAD;
                  col_d   = ~COL_ONE;
               end else begin
                  dcnt_d = dcnt_q + DW'(1);
               end
            end
         end
         ST_SCAN: begin
            if (scnt_q != '0) begin
               scnt_d = scnt_q - SW'(1);
            end else if (any_low) begin
               state_d     = ST_HIT;
               key_valid_d = 1'b1;
               key_code_d  = hit_code;
               key_held_d  = 1'b1;
               col_d       = '0;
               dcnt_d      = '0;
`ifdef KEY_REPEAT_EN
               rcnt_d      = REP_DLY_LOAD;
`endif
            end else if (c_q == C_LAST) begin
               state_d = ST_IDLE;
               col_d   = '0;
            end else begin
               c_d    = c_q + CW'(1);
               scnt_d = SETTLE_LOAD;
               col_d  = ~(COL_ONE << (c_q + CW'(1)));
            end
         end
         ST_HIT: begin
            state_d = ST_HELD;
            col_d   = '0;
         end
         ST_HELD: begin
            col_d = '0;
            if (tick) begin
               if (any_low) begin
                  // Any pressed tick restarts the release count; extra keys change nothing.
                  dcnt_d = '0;
`ifdef KEY_REPEAT_EN
                  if (rcnt_q == '0) begin
                     key_valid_d  = 1'b1;
                     key_repeat_d = 1'b1;
                     rcnt_d       = REP_RATE_LOAD;
                  end else begin
                     rcnt_d = rcnt_q - REP_W'(1);
                  end
`endif
               end else begin
`ifdef KEY_REPEAT_EN
                  rcnt_d = REP_DLY_LOAD;
`endif
                  if (dcnt_q == DB_LAST) begin
                     state_d    = ST_IDLE;
                     key_held_d = 1'b0;
                     dcnt_d     = '0;
                  end else begin
                     dcnt_d = dcnt_q + DW'(1);
                  end
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            col_d      = '0;
            key_held_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         dcnt_q      <= '0;
         scnt_q      <= '0;
         c_q         <= '0;
         col_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         scnt_q      <= scnt_d;
         c_q         <= c_d;
         col_q       <= col_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
      end
   end

`ifdef KEY_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt_q       <= '0;
         key_repeat_q <= 1'b0;
      end else begin
         rcnt_q       <= rcnt_d;
         key_repeat_q <= key_repeat_d;
      end
   end

   assign key_repeat = key_repeat_q;
`else
   assign key_repeat = 1'b0;
`endif

   assign col       = col_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Self-checking bench for matrix_key_scanner: keypad model, vector table, directed corners, random presses.
`timescale 1ns/1ps
module tb_matrix_key_scanner;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int TD    = 4;
   localparam int DB    = 3;
   localparam int SC    = 3;
   localparam int RDLY  = 5;
   localparam int RRATE = 2;
   localparam int NK    = ROWS * COLS;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [ROWS-1:0] row;
   logic [COLS-1:0] col;
   logic            key_valid;
   logic [3:0]      key_code;
   logic            key_held;
   logic            key_repeat;
   logic [NK-1:0]   pressed = '0;

   int errors = 0;
   int checks = 0;
   int new_pulses = 0;
   int rep_pulses = 0;

   typedef struct {
      logic [NK-1:0] mask;
      int            code;
      int            hold_tk;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   matrix_key_scanner #(
      .ROWS        (ROWS),
      .COLS        (COLS),
      .TICK_DIV    (TD),
      .DEBOUNCE_TK (DB),
      .SETTLE_CYC  (SC),
      .REPEAT_DLY  (RDLY),
      .REPEAT_RATE (RRATE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .row        (row),
      .col        (col),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_held   (key_held),
      .key_repeat (key_repeat)
   );

   // Passive keypad: a pressed key pulls its row low whenever its column is driven low.
   always_comb begin
      row = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (pressed[r*COLS+c] && !col[c]) row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (rst_n && key_valid) begin
         if (key_repeat) rep_pulses++;
         else            new_pulses++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference priority: lowest column first, then lowest row.
   function automatic int exp_code(input logic [NK-1:0] m);
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (m[r*COLS+c]) return r*COLS + c;
      return -1;
   endfunction

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_pulse(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (key_valid && !key_repeat) begin n = i; break; end
      end
   endtask

   task automatic wait_rep(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (key_valid && key_repeat) begin n = i; break; end
      end
   endtask

   task automatic wait_release(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (!key_held) begin n = i; break; end
      end
   endtask

   // Full press/hold/release transaction with latency and single-pulse checks.
   task automatic press_cycle(input string name, input logic [NK-1:0] m, input int hold_tk);
      int lat, rel, n0, code, nom;
      code = exp_code(m);
      nom  = 3 + DB*TD + (code % COLS + 1) * SC;
      n0   = new_pulses;
      pressed = m;
      wait_pulse(80, lat);
      check({name, "_code"}, (lat >= 0) ? int'(key_code) : -1, code);
      check_range({name, "_latency"}, lat, nom - TD + 1, nom);
      check({name, "_held"}, int'(key_held), 1);
      cycles(hold_tk * TD);
      pressed = '0;
      wait_release(80, rel);
      check_range({name, "_release"}, rel, 3 + (DB-1)*TD, 2 + DB*TD);
      cycles(2 * TD);
      check({name, "_pulses"}, new_pulses - n0, 1);
   endtask

   initial begin
      int lat, rel, n0, dropped;
      logic [NK-1:0] m;

      tbl[0] = '{mask: NK'(1) << 9,                     code: 9,  hold_tk: 20};
      tbl[1] = '{mask: (NK'(1) << 0)  | (NK'(1) << 15), code: 0,  hold_tk: 2};
      tbl[2] = '{mask: (NK'(1) << 5)  | (NK'(1) << 6),  code: 5,  hold_tk: 1};
      tbl[3] = '{mask: (NK'(1) << 14) | (NK'(1) << 11), code: 14, hold_tk: 1};
      tbl[4] = '{mask: (NK'(1) << 12) | (NK'(1) << 1),  code: 12, hold_tk: 0};
      tbl[5] = '{mask: (NK'(1) << 7)  | (NK'(1) << 15), code: 7,  hold_tk: 3};

      // Reset values
      cycles(3);
      check("rst_col", int'(col), 0);
      check("rst_valid", int'(key_valid), 0);
      check("rst_code", int'(key_code), 0);
      check("rst_held", int'(key_held), 0);
      check("rst_repeat", int'(key_repeat), 0);
      rst_n = 1'b1;
      cycles(2 * TD);

      for (int i = 0; i < 6; i++) begin
         check($sformatf("tbl%0d_model", i), exp_code(tbl[i].mask), tbl[i].code);
         press_cycle($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].hold_tk);
      end

      // Bounce: 2 ticks low then release, never reaches a scan
      n0 = new_pulses;
      pressed = NK'(1) << 9;
      cycles(2 * TD);
      pressed = '0;
      cycles(6 * TD);
      check("bounce_pulses", new_pulses - n0, 0);
      check("bounce_col", int'(col), 0);
      check("bounce_held", int'(key_held), 0);

      // Extra key while held is ignored
      n0 = new_pulses;
      pressed = (NK'(1) << 0) | (NK'(1) << 15);
      wait_pulse(80, lat);
      check("multi_code", (lat >= 0) ? int'(key_code) : -1, 0);
      pressed = pressed | (NK'(1) << 6);
      cycles(5 * TD);
      check("multi_extra_pulses", new_pulses - n0, 1);
      check("multi_extra_code", int'(key_code), 0);
      check("multi_extra_held", int'(key_held), 1);
      pressed = '0;
      wait_release(80, rel);
      check("multi_release_seen", (rel >= 0) ? 1 : 0, 1);
      cycles(2 * TD);

      // One-tick release glitch in HELD
      n0 = new_pulses;
      pressed = NK'(1) << 9;
      wait_pulse(80, lat);
      check("glitch_code", (lat >= 0) ? int'(key_code) : -1, 9);
      cycles(3 * TD);
      dropped = 0;
      pressed = '0;
      for (int i = 0; i < TD; i++) begin @(negedge clk); if (!key_held) dropped = 1; end
      pressed = NK'(1) << 9;
      for (int i = 0; i < 6 * TD; i++) begin @(negedge clk); if (!key_held) dropped = 1; end
      check("glitch_held_drop", dropped, 0);
      check("glitch_pulses", new_pulses - n0, 1);
      pressed = '0;
      wait_release(80, rel);
      check("glitch_release_seen", (rel >= 0) ? 1 : 0, 1);
      cycles(2 * TD);

      // Reset in the middle of a column scan
      pressed = NK'(1) << 15;
      lat = -1;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (col != '0) begin lat = i; break; end
      end
      check("scan_reached", (lat >= 0) ? 1 : 0, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_col", int'(col), 0);
      check("midrst_valid", int'(key_valid), 0);
      check("midrst_code", int'(key_code), 0);
      check("midrst_held", int'(key_held), 0);
      pressed = '0;
      cycles(3);
      n0 = new_pulses;
      rst_n = 1'b1;
      cycles(10 * TD);
      check("midrst_no_pulse", new_pulses - n0, 0);

`ifdef KEY_REPEAT_EN
      pressed = NK'(1) << 15;
      wait_pulse(80, lat);
      check("rep_first_code", (lat >= 0) ? int'(key_code) : -1, 15);
      wait_rep(80, lat);
      check_range("rep_first_delay", lat, RDLY*TD - TD + 2, RDLY*TD + 1);
      check("rep_first_rcode", int'(key_code), 15);
      for (int k = 0; k < 2; k++) begin
         wait_rep(80, lat);
         check($sformatf("rep_rate%0d", k), lat, RRATE*TD);
         check($sformatf("rep_code%0d", k), int'(key_code), 15);
      end
      check("rep_held", int'(key_held), 1);
      pressed = '0;
      wait_release(80, rel);
      check("rep_release_seen", (rel >= 0) ? 1 : 0, 1);
      cycles(2 * TD);
`endif

      // Randomized presses and bounces against the priority model
      for (int it = 0; it < 30; it++) begin
         m = '0;
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) m[$urandom_range(0, NK-1)] = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            n0 = new_pulses;
            pressed = m;
            cycles($urandom_range(1, (DB-1)*TD));
            pressed = '0;
            cycles(3 * TD);
            check($sformatf("rnd%0d_bounce", it), new_pulses - n0, 0);
         end else begin
            press_cycle($sformatf("rnd%0d", it), m, $urandom_range(0, 4));
         end
      end

`ifndef KEY_REPEAT_EN
      check("no_repeat_pulses", rep_pulses, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
